// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit control path.
package uart_pkg;

  localparam int unsigned DATA_W               = 8;
  localparam int unsigned SAMPLES_PER_BIT      = 3;
  localparam int unsigned FRAME_TIMEOUT_PULSES = 32;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_HUNT  = 2'd1,
    ST_FRAME = 2'd2
  } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with valid/ready on both sides and an occupancy output.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [LVL_W-1:0] lvl_q;
  logic             full;
  logic             push;
  logic             pop;

  always_comb begin
    full    = (lvl_q == LVL_W'(DEPTH));
    o_valid = (lvl_q != '0);
    pop     = o_valid && i_ready;
    // A full FIFO can still accept when the head leaves in the same cycle.
    o_ready = !full || pop;
    push    = i_valid && o_ready;
    o_data  = o_valid ? mem[rd_q] : '0;
    o_level = lvl_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_q] <= i_data;
        wr_q      <= wr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   lvl_q <= lvl_q + LVL_W'(1);
        2'b01:   lvl_q <= lvl_q - LVL_W'(1);
        default: lvl_q <= lvl_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: sample-pulse generator, frame supervisor,
// buffered byte stream and error statistics.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic [DIV_W-1:0]        i_div,
  output logic                    o_rxpulse,
  input  logic                    i_rxsync,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_rx_valid,
  input  logic                    i_rx_err,
  output logic [7:0]              o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_overrun,
  output logic [ERRCNT_W-1:0]     o_err_cnt,
  input  logic                    i_clr
);

  localparam int unsigned TMR_W = $clog2(FRAME_TIMEOUT_PULSES) + 1;

  rx_state_t            state_q;
  rx_state_t            state_d;
  logic [DIV_W-1:0]     cnt_q;
  logic [DIV_W-1:0]     div_eff;
  logic [TMR_W-1:0]     tmr_q;
  logic                 tmr_load;
  logic                 running;
  logic                 pulse;
  logic                 timeout;
  logic                 err_inc;
  logic                 rx_prev_q;
  logic                 rx_rise;
  logic                 push_ready;
  logic                 drop;
  logic [ERRCNT_W-1:0]  err_q;
  logic                 ovr_q;

  // Sample-pulse generator
  always_comb begin
    div_eff = (i_div < DIV_W'(2)) ? DIV_W'(2) : i_div;
    running = (state_q != ST_OFF);
    pulse   = running && !i_rxsync && (cnt_q == '0);
    rx_rise = i_rx_valid && !rx_prev_q;
    drop    = rx_rise && !push_ready;
  end

  assign o_rxpulse = pulse;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (!running) begin
      cnt_q <= '0;
    end else if (i_rxsync) begin
      // Half-period reload so sampling lands mid-bit after the start edge.
      cnt_q <= div_eff >> 1;
    end else if (cnt_q == '0) begin
      cnt_q <= div_eff - DIV_W'(1);
    end else begin
      cnt_q <= cnt_q - DIV_W'(1);
    end
  end

  // Frame supervisor
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    timeout  = (state_q == ST_FRAME) && pulse && (tmr_q == TMR_W'(1));
    err_inc  = (state_q == ST_FRAME) && (i_rx_err || timeout);
    case (state_q)
      ST_OFF: begin
        if (i_en) state_d = ST_HUNT;
      end
      ST_HUNT: begin
        if (i_rxsync) begin
          state_d  = ST_FRAME;
          tmr_load = 1'b1;
        end
      end
      ST_FRAME: begin
        if (rx_rise || i_rx_err || timeout) state_d = ST_HUNT;
      end
      default: state_d = ST_OFF;
    endcase
    if (!i_en) begin
      state_d  = ST_OFF;
      tmr_load = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_OFF;
      rx_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_prev_q <= i_rx_valid;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmr_q <= '0;
    end else if (tmr_load) begin
      tmr_q <= TMR_W'(FRAME_TIMEOUT_PULSES);
    end else if ((state_q == ST_FRAME) && pulse && (tmr_q != '0)) begin
      tmr_q <= tmr_q - TMR_W'(1);
    end
  end

  // Statistics; a clear coinciding with a new event keeps that event.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= '0;
      ovr_q <= 1'b0;
    end else if (i_clr) begin
      err_q <= err_inc ? ERRCNT_W'(1) : '0;
      ovr_q <= drop;
    end else begin
      if (err_inc && (err_q != '1)) err_q <= err_q + ERRCNT_W'(1);
      if (drop) ovr_q <= 1'b1;
    end
  end

  assign o_overrun = ovr_q;
  assign o_err_cnt = err_q;

  uart_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_data  (i_rx_data),
    .i_valid (rx_rise),
    .o_ready (push_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_level (o_level)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a byte scoreboard on the output stream.
module tb_uart_rx_ctrl;

  localparam int unsigned DIV_W    = 16;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned ERRCNT_W = 8;

  logic                   i_clk = 1'b0;
  logic                   i_rst_n;
  logic                   i_en;
  logic [DIV_W-1:0]       i_div;
  logic                   o_rxpulse;
  logic                   i_rxsync;
  logic [7:0]             i_rx_data;
  logic                   i_rx_valid;
  logic                   i_rx_err;
  logic [7:0]             o_data;
  logic                   o_valid;
  logic                   i_ready;
  logic [$clog2(DEPTH):0] o_level;
  logic                   o_overrun;
  logic [ERRCNT_W-1:0]    o_err_cnt;
  logic                   i_clr;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  uart_rx_ctrl #(
    .DIV_W    (DIV_W),
    .DEPTH    (DEPTH),
    .ERRCNT_W (ERRCNT_W)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_en),
    .i_div      (i_div),
    .o_rxpulse  (o_rxpulse),
    .i_rxsync   (i_rxsync),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .i_rx_err   (i_rx_err),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_level    (o_level),
    .o_overrun  (o_overrun),
    .o_err_cnt  (o_err_cnt),
    .i_clr      (i_clr)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts cycles until the next sample pulse (sampled 3 time units after each edge).
  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      @(posedge i_clk);
      #3;
      n++;
    end while (!o_rxpulse && n < 200);
  endtask

  // Scoreboard monitor: a transfer happens on any edge with o_valid & i_ready.
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid && i_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got %02h expected none", o_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (o_data !== exp_b) begin
          fails++;
          $display("FAIL sb_data: got %02h expected %02h", o_data, exp_b);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;
    int exp_err;
    logic [7:0] ovr_bytes [5];
    ovr_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    i_rst_n = 1'b0; i_en = 1'b0; i_div = '0; i_rxsync = 1'b0;
    i_rx_data = '0; i_rx_valid = 1'b0; i_rx_err = 1'b0; i_ready = 1'b0; i_clr = 1'b0;
    repeat (3) @(posedge i_clk);
    #3;
    check("rst_pulse", 32'(o_rxpulse), 0);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_data", 32'(o_data), 0);
    check("rst_level", 32'(o_level), 0);
    check("rst_overrun", 32'(o_overrun), 0);
    check("rst_errcnt", 32'(o_err_cnt), 0);

    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    repeat (3) @(posedge i_clk);
    #3;
    check("off_no_pulse", 32'(o_rxpulse), 0);

    // Pulse period, div=10 then div=0
    @(posedge i_clk); #1;
    i_en = 1'b1; i_div = 16'd10;
    wait_pulse(n);
    wait_pulse(n);
    check("period_div10_a", 32'(n), 10);
    wait_pulse(n);
    check("period_div10_b", 32'(n), 10);
    i_div = 16'd0;
    wait_pulse(n);
    wait_pulse(n);
    check("period_div0_a", 32'(n), 2);
    wait_pulse(n);
    check("period_div0_b", 32'(n), 2);

    // Resync on a cycle that would otherwise pulse
    i_div = 16'd10;
    wait_pulse(n);
    wait_pulse(n);
    repeat (10) @(posedge i_clk);
    #1;
    i_rxsync = 1'b1;
    #2;
    check("resync_suppress", 32'(o_rxpulse), 0);
    @(posedge i_clk); #1;
    i_rxsync = 1'b0;
    #2;
    n = 1;
    if (!o_rxpulse) begin
      wait_pulse(m);
      n = n + m;
    end
    check("resync_first", 32'(n), 6);
    wait_pulse(n);
    check("resync_period", 32'(n), 10);
    check("resync_state", 32'(dut.state_q), 2);

    // Frame timeout: two pulses used above, 30 to go
    repeat (29) wait_pulse(n);
    wait_pulse(n);
    check("timeout_last_pulse", 32'(n), 10);
    check("timeout_err_before", 32'(o_err_cnt), 0);
    check("timeout_state_before", 32'(dut.state_q), 2);
    @(posedge i_clk); #3;
    check("timeout_state_after", 32'(dut.state_q), 1);
    check("timeout_err_after", 32'(o_err_cnt), 1);

    // Normal receive: one byte in HUNT, one in FRAME
    @(posedge i_clk); #1;
    i_ready = 1'b1; i_rx_data = 8'h55; i_rx_valid = 1'b1;
    exp_q.push_back(8'h55);
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0;
    #2;
    check("rx1_latency_valid", 32'(o_valid), 1);
    @(posedge i_clk); #1;
    i_rxsync = 1'b1;
    @(posedge i_clk); #1;
    i_rxsync = 1'b0; i_rx_data = 8'hA3; i_rx_valid = 1'b1;
    exp_q.push_back(8'hA3);
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0;
    #2;
    check("rx2_latency_valid", 32'(o_valid), 1);
    check("rx2_state_hunt", 32'(dut.state_q), 1);
    @(posedge i_clk); #3;
    check("rx_level_zero", 32'(o_level), 0);
    check("rx_valid_zero", 32'(o_valid), 0);

    // Overrun with DEPTH=4
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge i_clk); #1;
      i_rx_data = ovr_bytes[k]; i_rx_valid = 1'b1;
      if (k < 4) exp_q.push_back(ovr_bytes[k]);
      @(posedge i_clk); #1;
      i_rx_valid = 1'b0;
      #2;
      if (k == 3) begin
        check("ovr_level_full", 32'(o_level), 4);
        check("ovr_not_yet", 32'(o_overrun), 0);
      end
    end
    check("ovr_set", 32'(o_overrun), 1);
    check("ovr_level_held", 32'(o_level), 4);
    @(posedge i_clk); #1;
    i_clr = 1'b1;
    @(posedge i_clk); #1;
    i_clr = 1'b0;
    #2;
    check("clr_overrun", 32'(o_overrun), 0);
    check("clr_errcnt", 32'(o_err_cnt), 0);

    // Push into a full FIFO while popping
    @(posedge i_clk); #1;
    i_ready = 1'b1; i_rx_data = 8'h66; i_rx_valid = 1'b1;
    exp_q.push_back(8'h66);
    @(posedge i_clk); #1;
    i_ready = 1'b0; i_rx_valid = 1'b0;
    #2;
    check("full_pushpop_level", 32'(o_level), 4);
    check("full_pushpop_no_ovr", 32'(o_overrun), 0);
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    repeat (6) @(posedge i_clk);
    #3;
    check("drain_level", 32'(o_level), 0);

    // Clear coinciding with an error increment
    @(posedge i_clk); #1;
    i_rxsync = 1'b1;
    @(posedge i_clk); #1;
    i_rxsync = 1'b0; i_rx_err = 1'b1; i_clr = 1'b1;
    @(posedge i_clk); #1;
    i_rx_err = 1'b0; i_clr = 1'b0;
    #2;
    check("clr_with_inc", 32'(o_err_cnt), 1);
    exp_err = 1;

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      @(posedge i_clk); #1;
      if (i == 150) check("err_mid", 32'(o_err_cnt), 32'(exp_err));
      i_rx_err = 1'b0; i_rxsync = 1'b1;
      @(posedge i_clk); #1;
      i_rxsync = 1'b0; i_rx_err = 1'b1;
      if (exp_err < 255) exp_err++;
    end
    @(posedge i_clk); #1;
    i_rx_err = 1'b0;
    #2;
    check("err_saturated", 32'(o_err_cnt), 255);

    // Asynchronous reset mid-frame with two bytes buffered
    i_ready = 1'b0;
    @(posedge i_clk); #1;
    i_rx_data = 8'h5A; i_rx_valid = 1'b1;
    exp_q.push_back(8'h5A);
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0;
    @(posedge i_clk); #1;
    i_rx_data = 8'hC3; i_rx_valid = 1'b1;
    exp_q.push_back(8'hC3);
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0; i_rxsync = 1'b1;
    @(posedge i_clk); #1;
    i_rxsync = 1'b0;
    #2;
    check("pre_rst_level", 32'(o_level), 2);
    check("pre_rst_state", 32'(dut.state_q), 2);
    #1;
    i_rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_level", 32'(o_level), 0);
    check("arst_valid", 32'(o_valid), 0);
    check("arst_data", 32'(o_data), 0);
    check("arst_errcnt", 32'(o_err_cnt), 0);
    check("arst_pulse", 32'(o_rxpulse), 0);
    check("arst_overrun", 32'(o_overrun), 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    #2;
    check("post_rst_off", 32'(dut.state_q), 0);
    @(posedge i_clk); #3;
    check("post_rst_hunt", 32'(dut.state_q), 1);
    check("post_rst_pulse", 32'(o_rxpulse), 1);

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the 8N1 UART receiver.
- Generates the receiver's 3x-oversample sample pulse from a programmable divisor.
- Re-centres the pulse phase on each start-bit sync.
- Supervises each frame with a timeout.
- Turns the receiver's level-style valid into a buffered valid/ready stream.
- Keeps overrun and error statistics.

It sits between the UART receiver and the consumer logic, e.g. a command parser.

## Interface
- `DIV_W`, 16, width of the sample-period divisor.
- `DEPTH`, 4, receive FIFO depth in bytes; must be a power of 2, at least 2.
- `ERRCNT_W`, 8, width of the saturating error counter.

- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_en`  in  1  controller enable; 0 forces the OFF state.
- `i_div`  in  DIV_W  clocks per sample pulse; values 0 and 1 are treated as 2; sampled on every reload.
- `o_rxpulse`  out  1  sample pulse to the receiver, one cycle wide.
- `i_rxsync`  in  1  start-bit sync pulse from the receiver.
- `i_rx_data`  in  8  received byte from the receiver.
- `i_rx_valid`  in  1  receiver valid, level; a new byte is signalled on its rising edge.
- `i_rx_err`  in  1  receiver framing-error pulse.
- `o_data`  out  8  FIFO head byte.
- `o_valid`  out  1  FIFO not empty.
- `i_ready`  in  1  consumer accepts `o_data`.
- `o_level`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `o_overrun`  out  1  sticky: a byte was dropped because the FIFO was full.
- `o_err_cnt`  out  ERRCNT_W  saturating count of framing errors plus timeouts.
- `i_clr`  in  1  synchronous clear of `o_overrun` and `o_err_cnt`.

## Operation
**Reset values:** all outputs 0, state OFF, FIFO empty, `o_level`=0.

**Pulse generator:** down-counter `cnt`.
- When `cnt`=0: `o_rxpulse`=1 and reload `cnt` = max(`i_div`,2)-1.
- When `i_rxsync`=1: reload `cnt` = max(`i_div`,2)>>1 and suppress any pulse that cycle. This centres the sampling on the bit.
- The counter runs only in HUNT and FRAME; in OFF `cnt` is held at 0 and `o_rxpulse`=0.

**FSM:**
- OFF -> HUNT when `i_en`=1.
- HUNT -> FRAME on `i_rxsync`; load the frame timer with 32 pulses.
- FRAME:
  - Decrement the timer on each `o_rxpulse`.
  - On rising edge of `i_rx_valid` -> HUNT and push the byte.
  - On `i_rx_err` -> HUNT and increment the error count.
  - Timer reaches 0 -> HUNT and increment the error count (timeout).
- Any state -> OFF when `i_en`=0. FIFO contents and counters are kept.

**Edge detection:** `i_rx_valid` is registered into a previous-value flop (reset 0); a rising edge is `i_rx_valid` & !prev. A rising edge seen outside FRAME is still pushed.

**FIFO:**
- Push and pop in the same cycle while the FIFO holds 1 to DEPTH-1 entries: level is unchanged.
- Pop when empty is ignored (`o_valid`=0).
- Push when full while not popping: byte dropped, `o_overrun`=1.
- Push when full with a simultaneous pop: accepted, no overrun.
- Pointers wrap modulo DEPTH.

**Error counter:** saturates at 2^ERRCNT_W-1. If `i_clr` and an increment occur in the same cycle, the result is 1. If `i_clr` and an overrun occur in the same cycle, `o_overrun`=1.

## Timing
- `o_rxpulse` period = max(`i_div`,2) clocks in steady state. After `i_rxsync` in cycle t, the first pulse is at cycle t+(max(`i_div`,2)>>1)+1.
- Byte latency: from the `i_rx_valid` rising edge at cycle t, `o_valid`=1 and `o_data` are valid at t+1.
- `o_valid`/`o_data` come from registers only; `o_data` holds while `o_valid` & !`i_ready`.
- A pop happens on a clock edge with `o_valid` & `i_ready`.
- `o_level` and `o_overrun` update one cycle after the triggering event.
- The error counter updates at t+1 for an `i_rx_err` or timeout at t.
- Asynchronous reset mid-frame: return to OFF immediately and empty the FIFO.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state encoding (OFF=0, HUNT=1, FRAME=2);
  - `FRAME_TIMEOUT_PULSES`=32;
  - `SAMPLES_PER_BIT`=3;
  - data width 8.
- One sub-module, `uart_fifo` (parameter DEPTH, width 8; valid/ready on both sides, level output), reused later by the TX path.
- Pulse generator, FSM and counters stay in `uart_rx_ctrl`.

## Test plan
- **Pulse period:** `i_div`=10, `i_en`=1 -> `o_rxpulse` every 10 clocks; `i_div`=0 -> every 2 clocks.
- **Resync:** `i_div`=10, `i_rxsync` at cycle t -> no pulse at t, next pulse at t+6, then every 10 clocks; state FRAME.
- **Normal receive:** bytes 0x55, 0xA3 delivered via `i_rx_valid` rising edges, `i_ready`=1 -> `o_data` 0x55 then 0xA3, each 1 cycle after its edge; `o_level` returns to 0.
- **Overrun:** `i_ready`=0, DEPTH=4, 5 bytes pushed -> `o_level`=4, `o_overrun`=1, consumer then reads the first 4 bytes in order; `i_clr` -> `o_overrun`=0.
- **Timeout and error saturation:** `i_rxsync` then 32 pulses with no valid -> HUNT, `o_err_cnt`=1; 300 `i_rx_err` pulses with ERRCNT_W=8 -> `o_err_cnt`=255.
- **Reset mid-operation:** assert `i_rst_n`=0 in FRAME with 2 bytes buffered -> all outputs 0 and `o_level`=0 at once; after release, OFF -> HUNT with `i_en`=1.
